// File: rtl/dsp_elastic_pipe.sv
// rtl/dsp_elastic_pipe.sv - elastic valid/ready register chain with bubble collapse, ce freeze, flush and occupancy count
module dsp_elastic_pipe #(
    parameter int WIDTH = 18,
    parameter int DEPTH = 2,
    parameter int CNT_W = (DEPTH < 1) ? 1 : $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ce,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [CNT_W-1:0] count
);

    generate
        if (DEPTH == 0) begin : g_pass
            // No storage: the chain degenerates to wires, gated so no transfer completes while frozen or flushing.
            logic unused_clk;
            assign unused_clk = clk;
            assign out_valid  = in_valid;
            assign out_data   = in_data;
            assign in_ready   = out_ready & ce & ~flush & ~rst;
            assign count      = '0;
        end else begin : g_regs
            logic [DEPTH-1:0] v_q;
            logic [DEPTH-1:0] v_d;
            logic [WIDTH-1:0] d_q [DEPTH];
            logic [WIDTH-1:0] d_d [DEPTH];
            logic [CNT_W-1:0] count_q;
            logic [CNT_W-1:0] count_d;
            logic [DEPTH-1:0] rdy;
            // Upstream view of each stage: index 0 is the input port, index k+1 is stage k.
            logic [DEPTH:0]   up_v;
            logic [WIDTH-1:0] up_d [DEPTH+1];

            // Ready chain from the output backwards; an empty stage is always ready, which collapses bubbles.
            always_comb begin
                logic r;
                r = out_ready;
                rdy = '0;
                for (int k = DEPTH - 1; k >= 0; k--) begin
                    r = ~v_q[k] | r;
                    rdy[k] = r;
                end
            end

            // Gather the word presented to each stage by its upstream neighbour.
            always_comb begin
                up_v    = {v_q, in_valid};
                up_d[0] = in_data;
                for (int k = 0; k < DEPTH; k++) begin
                    up_d[k+1] = d_q[k];
                end
            end

            // Next-state: flush drops all valids but keeps data; a ready stage takes its upstream word, data only when valid.
            always_comb begin
                v_d = v_q;
                for (int k = 0; k < DEPTH; k++) begin
                    d_d[k] = d_q[k];
                end
                if (flush) begin
                    v_d = '0;
                end else if (ce) begin
                    for (int k = 0; k < DEPTH; k++) begin
                        if (rdy[k]) begin
                            v_d[k] = up_v[k];
                            if (up_v[k]) begin
                                d_d[k] = up_d[k];
                            end
                        end
                    end
                end
                count_d = '0;
                for (int k = 0; k < DEPTH; k++) begin
                    count_d = count_d + CNT_W'(v_d[k]);
                end
            end

            // Stage registers with synchronous reset; count tracks the popcount of the valids it is loaded with.
            always_ff @(posedge clk) begin
                if (rst) begin
                    v_q     <= '0;
                    count_q <= '0;
                    for (int k = 0; k < DEPTH; k++) begin
                        d_q[k] <= '0;
                    end
                end else begin
                    v_q     <= v_d;
                    count_q <= count_d;
                    for (int k = 0; k < DEPTH; k++) begin
                        d_q[k] <= d_d[k];
                    end
                end
            end

            assign in_ready  = ce & ~flush & ~rst & rdy[0];
            assign out_valid = v_q[DEPTH-1];
            assign out_data  = d_q[DEPTH-1];
            assign count     = count_q;
        end
    endgenerate

endmodule

// File: tb/tb_dsp_elastic_pipe.sv
// tb/tb_dsp_elastic_pipe.sv - randomized and directed check of dsp_elastic_pipe against a queue model
module tb_dsp_elastic_pipe;
    localparam int W  = 18;
    localparam int D  = 3;
    localparam int CW = 2;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         ce = 1'b1;
    logic         flush = 1'b0;
    logic         in_valid = 1'b0;
    logic [W-1:0] in_data = '0;
    logic         out_ready = 1'b1;
    logic         in_ready;
    logic         out_valid;
    logic [W-1:0] out_data;
    logic [CW-1:0] count;
    logic         z_in_ready;
    logic         z_out_valid;
    logic [W-1:0] z_out_data;
    logic         z_count;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [W-1:0] data;
        int           pos;
    } ent_t;
    ent_t mq[$];

    always #5 clk = ~clk;

    dsp_elastic_pipe #(.WIDTH(W), .DEPTH(D)) u_dut (
        .clk(clk), .rst(rst), .ce(ce), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .count(count)
    );

    dsp_elastic_pipe #(.WIDTH(W), .DEPTH(0)) u_dut0 (
        .clk(clk), .rst(rst), .ce(ce), .flush(flush),
        .in_valid(in_valid), .in_ready(z_in_ready), .in_data(in_data),
        .out_valid(z_out_valid), .out_ready(out_ready), .out_data(z_out_data),
        .count(z_count)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Each word moves one position toward the output unless blocked by the word ahead of it.
    // Returns the lowest position the word ahead will occupy (D+1 / D when the chain is empty).
    function automatic int model_limit(input bit ordy);
        int lim;
        int np;
        lim = ordy ? D + 1 : D;
        foreach (mq[i]) begin
            np  = (mq[i].pos + 1 < lim - 1) ? mq[i].pos + 1 : lim - 1;
            lim = np;
        end
        return lim;
    endfunction

    task automatic cyc(input bit r, input bit c, input bit f, input bit iv,
                       input logic [W-1:0] id, input bit ordy, output bit acc);
        ent_t nq[$];
        ent_t e;
        int   lim;
        int   np;
        bit   exp_rdy;
        rst = r; ce = c; flush = f; in_valid = iv; in_data = id; out_ready = ordy;
        @(negedge clk);
        lim     = model_limit(ordy);
        exp_rdy = c && !f && !r && (lim >= 1);
        check("in_ready", in_ready, exp_rdy);
        check("out_valid", out_valid, (mq.size() > 0 && mq[0].pos == D - 1));
        if (mq.size() > 0 && mq[0].pos == D - 1) check("out_data", out_data, mq[0].data);
        check("count", count, mq.size());
        check("z_out_valid", z_out_valid, iv);
        check("z_out_data", z_out_data, id);
        check("z_in_ready", z_in_ready, ordy && c && !f && !r);
        check("z_count", z_count, 0);
        acc = 1'b0;
        nq  = mq;
        if (r || f) begin
            nq.delete();
        end else if (c) begin
            nq.delete();
            lim = ordy ? D + 1 : D;
            foreach (mq[i]) begin
                np  = (mq[i].pos + 1 < lim - 1) ? mq[i].pos + 1 : lim - 1;
                lim = np;
                if (np < D) begin
                    e.data = mq[i].data;
                    e.pos  = np;
                    nq.push_back(e);
                end
            end
            if (iv && lim >= 1) begin
                e.data = id;
                e.pos  = 0;
                nq.push_back(e);
                acc = 1'b1;
            end
        end
        @(posedge clk);
        #1;
        mq = nq;
    endtask

    initial begin
        bit           acc;
        bit           pend;
        logic [W-1:0] pend_data;
        bit           r, f, c, o;
        pend = 1'b0;
        pend_data = '0;

        // Reset state
        cyc(1, 1, 0, 0, 0, 1, acc);
        cyc(1, 1, 0, 1, 18'h155, 1, acc);
        check("rst_out_data", out_data, 0);
        check("rst_count", count, 0);
        check("rst_out_valid", out_valid, 0);

        // Back-to-back stream with no backpressure: first word visible after 3 edges
        for (int i = 1; i <= 5; i++) begin
            cyc(0, 1, 0, 1, W'(i), 1, acc);
            check("t1_acc", acc, 1);
            if (i == 3) begin
                check("t1_latency_v", out_valid, 1);
                check("t1_latency_d", out_data, 1);
            end
        end
        check("t1_count", count, 3);
        for (int i = 0; i < 4; i++) cyc(0, 1, 0, 0, 0, 1, acc);

        // Fill with output stalled, fourth word held, then release
        for (int i = 0; i < 3; i++) cyc(0, 1, 0, 1, W'(10 + i), 0, acc);
        check("t2_full", count, 3);
        cyc(0, 1, 0, 1, W'(13), 0, acc);
        check("t2_held", acc, 0);
        cyc(0, 1, 0, 1, W'(13), 1, acc);
        check("t2_full_accept", acc, 1);
        for (int i = 0; i < 5; i++) cyc(0, 1, 0, 0, 0, 1, acc);
        check("t2_drained", count, 0);

        // Bubble collapse behind a stalled output word
        cyc(0, 1, 0, 1, W'(18'h11), 0, acc);
        cyc(0, 1, 0, 0, 0, 0, acc);
        cyc(0, 1, 0, 0, 0, 0, acc);
        cyc(0, 1, 0, 1, 18'h2AAAA, 0, acc);
        cyc(0, 1, 0, 0, 0, 0, acc);
        check("t3_count", count, 2);
        for (int i = 0; i < 4; i++) cyc(0, 1, 0, 0, 0, 1, acc);

        // Clock-enable freeze mid-stream
        for (int i = 0; i < 3; i++) cyc(0, 1, 0, 1, W'(20 + i), 1, acc);
        for (int i = 0; i < 4; i++) begin
            cyc(0, 0, 0, 1, W'(23), 1, acc);
            check("t4_frozen_count", count, 3);
        end
        for (int i = 3; i < 6; i++) cyc(0, 1, 0, 1, W'(20 + i), 1, acc);
        for (int i = 0; i < 4; i++) cyc(0, 1, 0, 0, 0, 1, acc);

        // Flush a full chain while a word is offered
        for (int i = 0; i < 3; i++) cyc(0, 1, 0, 1, W'(30 + i), 0, acc);
        cyc(0, 1, 1, 1, W'(18'h33), 0, acc);
        check("t5_flush_acc", acc, 0);
        check("t5_flush_count", count, 0);
        check("t5_flush_valid", out_valid, 0);
        cyc(0, 1, 0, 1, W'(18'h33), 1, acc);
        cyc(0, 1, 0, 0, 0, 1, acc);
        cyc(0, 1, 0, 0, 0, 1, acc);
        check("t5_resend_v", out_valid, 1);
        check("t5_resend_d", out_data, 18'h33);
        cyc(0, 1, 0, 0, 0, 1, acc);

        // Reset during a full stream
        for (int i = 0; i < 4; i++) cyc(0, 1, 0, 1, W'(40 + i), 1, acc);
        cyc(1, 1, 0, 1, W'(44), 1, acc);
        check("t6_rst_valid", out_valid, 0);
        check("t6_rst_count", count, 0);
        check("t6_rst_data", out_data, 0);

        // Randomized traffic, upstream holds each word until accepted
        for (int n = 0; n < 3000; n++) begin
            if (!pend && $urandom_range(0, 99) < 60) begin
                pend = 1'b1;
                pend_data = W'($urandom);
            end
            r = ($urandom_range(0, 149) == 0);
            f = ($urandom_range(0, 39) == 0);
            c = ($urandom_range(0, 7) != 0);
            o = ($urandom_range(0, 2) != 0);
            cyc(r, c, f, pend, pend_data, o, acc);
            if (acc) pend = 1'b0;
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
